jtframe_dump_trig: RTL and testbench

JTFRAME_DUMP_TRIG -- requirements
Module: jtframe_dump_trig

---
 rtl/jtframe_dump_pkg.sv | 14 +
 rtl/jtframe_edge.sv | 21 ++
 rtl/jtframe_dump_trig.sv | 109 ++++++++++
 tb/tb_jtframe_dump_trig.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dump_pkg.sv
// Shared constants for the dump trigger: FSM state encoding and trigger modes.
package jtframe_dump_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] MODE_OFF       = 2'd0;
    localparam logic [1:0] MODE_IMMEDIATE = 2'd1;
    localparam logic [1:0] MODE_FRAME     = 2'd2;
    localparam logic [1:0] MODE_LOADEND   = 2'd3;

endpackage

// File: rtl/jtframe_edge.sv
// Single-register edge detector: compares the live input with last cycle's copy.
module jtframe_edge (
    input  logic rst,
    input  logic clk,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic last;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= 1'b0;
        else     last <= din;
    end

    assign rise = din & ~last;
    assign fall = ~din & last;

endmodule

// File: rtl/jtframe_dump_trig.sv
// Dump-window trigger: opens a per-channel dump enable immediately, at a given
// frame, or after ROM download ends, and closes it after frame_len frames.
module jtframe_dump_trig
    import jtframe_dump_pkg::*;
#(
    parameter int CH    = 4,
    parameter int FCW   = 32,
    parameter int GUARD = 16
) (
    input  logic           rst,
    input  logic           clk,
    input  logic           vs,
    input  logic           dwnld,
    input  logic [1:0]     mode,
    input  logic [FCW-1:0] start_frame,
    input  logic [FCW-1:0] frame_len,
    input  logic [CH-1:0]  en_mask,
    output logic [FCW-1:0] frame_cnt,
    output logic [CH-1:0]  dump_on,
    output logic           dumping,
    output logic           done
);

    localparam int GW = $clog2(GUARD + 2);

    logic           vs_fall, vs_rise_unused;
    logic           dl_fall, dl_rise;
    logic [1:0]     state, state_nx;
    logic [1:0]     trig_mode;
    logic [FCW-1:0] win_cnt, win_next;
    logic [GW-1:0]  guard_cnt;
    logic           guard_ok;
    logic           done_nx;

    jtframe_edge u_vs_edge (
        .rst  (rst),
        .clk  (clk),
        .din  (vs),
        .rise (vs_rise_unused),
        .fall (vs_fall)
    );

    jtframe_edge u_dl_edge (
        .rst  (rst),
        .clk  (clk),
        .din  (dwnld),
        .rise (dl_rise),
        .fall (dl_fall)
    );

    assign guard_ok = (guard_cnt == GW'(GUARD));
    assign win_next = (win_cnt == {FCW{1'b1}}) ? win_cnt : win_cnt + FCW'(1);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                case (mode)
                    MODE_IMMEDIATE:          state_nx = ST_ACTIVE;
                    MODE_FRAME, MODE_LOADEND: state_nx = ST_ARMED;
                    default:                 state_nx = ST_IDLE;
                endcase
            end
            ST_ARMED: begin
                if (trig_mode == MODE_FRAME && vs_fall && frame_cnt == start_frame)
                    state_nx = ST_ACTIVE;
                else if (trig_mode == MODE_LOADEND && dl_fall && guard_ok)
                    state_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // Window close beats a simultaneous download restart.
                if (vs_fall && frame_len != '0 && win_next == frame_len) begin
                    state_nx = ST_DONE;
                    done_nx  = 1'b1;
                end else if (trig_mode == MODE_LOADEND && dl_rise) begin
                    state_nx = ST_ARMED;
                end
            end
            default: state_nx = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            trig_mode <= MODE_OFF;
            frame_cnt <= '0;
            win_cnt   <= '0;
            guard_cnt <= '0;
            dump_on   <= '0;
            dumping   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) trig_mode <= mode;
            if (vs_fall) frame_cnt <= frame_cnt + FCW'(1);
            if (!guard_ok) guard_cnt <= guard_cnt + GW'(1);
            // Held at zero outside ACTIVE, so entry and re-arm both start a fresh window.
            if (state != ST_ACTIVE) win_cnt <= '0;
            else if (vs_fall)       win_cnt <= win_next;
            dump_on <= en_mask & {CH{state == ST_ACTIVE}};
            dumping <= (state == ST_ACTIVE);
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_dump_trig.sv
// Directed bench: a vector table of whole-scenario runs plus hand sequences for
// latency, guard, re-arm, tie-break, counter wrap and asynchronous reset.
module tb_jtframe_dump_trig;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b0;
    logic        dwnld = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] start_frame = '0;
    logic [31:0] frame_len = '0;
    logic [3:0]  en_mask = '0;
    logic [31:0] frame_cnt;
    logic [3:0]  dump_on;
    logic        dumping;
    logic        done;

    logic [1:0]  mode4 = 2'd0;
    logic [3:0]  start4 = '0;
    logic [3:0]  len4 = '0;
    logic [3:0]  frame_cnt4;
    logic [3:0]  dump_on4;
    logic        dumping4;
    logic        done4;

    int total = 0;
    int bad = 0;
    int done_total = 0;
    int done_base = 0;

    always #5 clk = ~clk;

    jtframe_dump_trig #(.CH(4), .FCW(32), .GUARD(16)) dut (
        .rst(rst), .clk(clk), .vs(vs), .dwnld(dwnld), .mode(mode),
        .start_frame(start_frame), .frame_len(frame_len), .en_mask(en_mask),
        .frame_cnt(frame_cnt), .dump_on(dump_on), .dumping(dumping), .done(done)
    );

    jtframe_dump_trig #(.CH(4), .FCW(4), .GUARD(16)) dut4 (
        .rst(rst), .clk(clk), .vs(vs), .dwnld(dwnld), .mode(mode4),
        .start_frame(start4), .frame_len(len4), .en_mask(en_mask),
        .frame_cnt(frame_cnt4), .dump_on(dump_on4), .dumping(dumping4), .done(done4)
    );

    always @(negedge clk) if (done) done_total++;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] start;
        logic [31:0] len;
        logic [3:0]  mask;
        int          frames;
        logic        exp_dumping;
        logic [3:0]  exp_dump_on;
        logic [31:0] exp_fc;
        int          exp_dones;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [31:0] s, input logic [31:0] l,
                            input logic [3:0] msk, input logic dl);
        rst = 1'b1; vs = 1'b0; dwnld = dl;
        mode = m; start_frame = s; frame_len = l; en_mask = msk;
        tick(1);
        done_base = done_total;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic frame();
        vs = 1'b1;
        tick(3);
        vs = 1'b0;
        tick(3);
    endtask

    task automatic guard_run(input int e, input logic exp);
        do_reset(2'd3, 32'd0, 32'd0, 4'b1111, 1'b1);
        tick(e);
        dwnld = 1'b0;
        tick(2);
        check($sformatf("guard_fall_at_%0d", e), {31'd0, dumping}, {31'd0, exp});
    endtask

    initial begin
        //          mode  start  len    mask     fr  dmp  dump_on  fc    dones
        vecs[0]  = '{2'd1, 32'd0, 32'd0, 4'b0101, 10, 1'b1, 4'b0101, 32'd10, 0};
        vecs[1]  = '{2'd1, 32'd0, 32'd3, 4'b1111, 3,  1'b0, 4'b0000, 32'd3,  1};
        vecs[2]  = '{2'd1, 32'd0, 32'd3, 4'b1111, 2,  1'b1, 4'b1111, 32'd2,  0};
        vecs[3]  = '{2'd2, 32'd5, 32'd3, 4'b0011, 5,  1'b0, 4'b0000, 32'd5,  0};
        vecs[4]  = '{2'd2, 32'd5, 32'd3, 4'b0011, 6,  1'b1, 4'b0011, 32'd6,  0};
        vecs[5]  = '{2'd2, 32'd5, 32'd3, 4'b0011, 8,  1'b1, 4'b0011, 32'd8,  0};
        vecs[6]  = '{2'd2, 32'd5, 32'd3, 4'b0011, 9,  1'b0, 4'b0000, 32'd9,  1};
        vecs[7]  = '{2'd2, 32'd0, 32'd1, 4'b1010, 2,  1'b0, 4'b0000, 32'd2,  1};
        vecs[8]  = '{2'd2, 32'd0, 32'd1, 4'b1010, 1,  1'b1, 4'b1010, 32'd1,  0};
        vecs[9]  = '{2'd0, 32'd0, 32'd0, 4'b1111, 4,  1'b0, 4'b0000, 32'd4,  0};
        vecs[10] = '{2'd3, 32'd0, 32'd0, 4'b1111, 3,  1'b0, 4'b0000, 32'd3,  0};
        vecs[11] = '{2'd1, 32'd0, 32'd0, 4'b0000, 2,  1'b1, 4'b0000, 32'd2,  0};
        vecs[12] = '{2'd2, 32'd3, 32'd0, 4'b1100, 12, 1'b1, 4'b1100, 32'd12, 0};
        vecs[13] = '{2'd2, 32'd5, 32'd3, 4'b0011, 12, 1'b0, 4'b0000, 32'd12, 1};

        // Reset state, sampled while reset is held.
        tick(2);
        check("rst_dump_on", {28'd0, dump_on}, 32'd0);
        check("rst_dumping", {31'd0, dumping}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_reset(vecs[i].mode, vecs[i].start, vecs[i].len, vecs[i].mask, 1'b0);
            tick(2);
            for (int f = 0; f < vecs[i].frames; f++) frame();
            tick(2);
            check($sformatf("vec%0d_dumping", i), {31'd0, dumping}, {31'd0, vecs[i].exp_dumping});
            check($sformatf("vec%0d_dump_on", i), {28'd0, dump_on}, {28'd0, vecs[i].exp_dump_on});
            check($sformatf("vec%0d_frame_cnt", i), frame_cnt, vecs[i].exp_fc);
            check($sformatf("vec%0d_dones", i), done_total - done_base, vecs[i].exp_dones);
        end

        // Immediate mode: two-cycle latency from reset release, one-cycle mask latency.
        do_reset(2'd1, 32'd0, 32'd0, 4'b0101, 1'b0);
        tick(1);
        check("imm_edge1_dump_on", {28'd0, dump_on}, 32'd0);
        tick(1);
        check("imm_edge2_dump_on", {28'd0, dump_on}, 32'h5);
        en_mask = 4'b1111;
        #3;
        check("mask_hold_dump_on", {28'd0, dump_on}, 32'h5);
        tick(1);
        check("mask_new_dump_on", {28'd0, dump_on}, 32'hf);

        // Download-end trigger: early fall ignored, later fall accepted.
        do_reset(2'd3, 32'd0, 32'd0, 4'b0110, 1'b1);
        tick(8);
        dwnld = 1'b0;
        tick(3);
        check("early_fall_dumping", {31'd0, dumping}, 32'd0);
        tick(9);
        dwnld = 1'b1;
        tick(20);
        dwnld = 1'b0;
        tick(1);
        check("late_fall_c41_dumping", {31'd0, dumping}, 32'd0);
        tick(1);
        check("late_fall_c42_dumping", {31'd0, dumping}, 32'd1);
        check("late_fall_dump_on", {28'd0, dump_on}, 32'h6);

        guard_run(15, 1'b0);
        guard_run(16, 1'b1);

        // Re-arm on download restart; window restarts from zero after re-entry.
        do_reset(2'd3, 32'd0, 32'd2, 4'b1111, 1'b1);
        tick(16);
        dwnld = 1'b0;
        tick(2);
        check("rearm_active", {31'd0, dumping}, 32'd1);
        frame();
        check("rearm_win1", {31'd0, dumping}, 32'd1);
        dwnld = 1'b1;
        tick(2);
        check("rearm_dropped", {31'd0, dumping}, 32'd0);
        check("rearm_dump_on", {28'd0, dump_on}, 32'd0);
        check("rearm_no_done", done_total - done_base, 32'd0);
        dwnld = 1'b0;
        tick(2);
        check("rearm_reentered", {31'd0, dumping}, 32'd1);
        frame();
        check("rearm_win_cleared", {31'd0, dumping}, 32'd1);
        frame();
        check("rearm_closed", {31'd0, dumping}, 32'd0);
        check("rearm_done_cnt", done_total - done_base, 32'd1);

        // Window close coinciding with download restart: DONE wins and is terminal.
        do_reset(2'd3, 32'd0, 32'd1, 4'b1111, 1'b1);
        tick(16);
        dwnld = 1'b0;
        tick(2);
        check("tie_active", {31'd0, dumping}, 32'd1);
        vs = 1'b1;
        tick(2);
        vs = 1'b0;
        dwnld = 1'b1;
        tick(3);
        check("tie_done_cnt", done_total - done_base, 32'd1);
        check("tie_dumping", {31'd0, dumping}, 32'd0);
        dwnld = 1'b0;
        tick(3);
        check("tie_terminal", {31'd0, dumping}, 32'd0);

        // Narrow counter: trigger at the last count, then wrap.
        mode4 = 2'd2; start4 = 4'd15; len4 = 4'd2;
        do_reset(2'd0, 32'd0, 32'd0, 4'b1111, 1'b0);
        tick(2);
        repeat (15) frame();
        check("wrap_armed_dumping", {31'd0, dumping4}, 32'd0);
        check("wrap_fc15", {28'd0, frame_cnt4}, 32'd15);
        frame();
        check("wrap_trig_dumping", {31'd0, dumping4}, 32'd1);
        check("wrap_trig_dump_on", {28'd0, dump_on4}, 32'hf);
        check("wrap_fc0", {28'd0, frame_cnt4}, 32'd0);
        frame();
        frame();
        check("wrap_closed", {31'd0, dumping4}, 32'd0);
        check("wrap_fc2", {28'd0, frame_cnt4}, 32'd2);
        mode4 = 2'd0;

        // Asynchronous reset mid-window.
        do_reset(2'd1, 32'd0, 32'd0, 4'b0101, 1'b0);
        tick(2);
        frame();
        frame();
        check("arst_pre_dump_on", {28'd0, dump_on}, 32'h5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dump_on", {28'd0, dump_on}, 32'd0);
        check("arst_dumping", {31'd0, dumping}, 32'd0);
        check("arst_frame_cnt", frame_cnt, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("arst_reentry_dump_on", {28'd0, dump_on}, 32'h5);
        check("arst_reentry_dumping", {31'd0, dumping}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
